// File: rtl/if_stage.sv
// ============================================================================
// Module   : if_stage
// Brief    : MIPS instruction-fetch stage with PC, imem handshake and IF/ID
//            register. Optional perf counters when IF_PERF_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hdu_out,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pipe_ifid_instr,
    output logic [31:0] pipe_ifid_pc4,
    output logic        pipe_ifid_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_count
`endif
);

    localparam logic [0:0] c_st_fetch      = 1'b0;
    localparam logic [0:0] c_st_wait_flush = 1'b1;

    logic [0:0]  r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_instr, w_instr_nxt;
    logic [31:0] r_pc4, w_pc4_nxt;
    logic        r_valid, w_valid_nxt;
    logic [31:0] w_pc_plus4;

    assign w_pc_plus4      = r_pc + 32'd4;
    assign imem_addr       = r_pc;
    assign imem_req        = ~reset;
    assign pipe_ifid_instr = r_instr;
    assign pipe_ifid_pc4   = r_pc4;
    assign pipe_ifid_valid = r_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_pc4_nxt   = r_pc4;
        w_valid_nxt = r_valid;
        if (branch_taken) begin
            // A flush wins over a stall: the held ID instruction is on the wrong path.
            w_pc_nxt    = {branch_target[31:2], 2'b00};
            w_instr_nxt = NOP_INSTR;
            w_pc4_nxt   = 32'd0;
            w_valid_nxt = 1'b0;
            w_state_nxt = imem_ready ? c_st_fetch : c_st_wait_flush;
        end else if (hdu_out) begin
            w_state_nxt = r_state;
        end else if (r_state == c_st_wait_flush) begin
            w_instr_nxt = NOP_INSTR;
            w_pc4_nxt   = 32'd0;
            w_valid_nxt = 1'b0;
            if (imem_ready) begin
                w_state_nxt = c_st_fetch;
            end
        end else if (!imem_ready) begin
            w_instr_nxt = NOP_INSTR;
            w_pc4_nxt   = 32'd0;
            w_valid_nxt = 1'b0;
        end else begin
            w_instr_nxt = imem_rdata;
            w_pc4_nxt   = w_pc_plus4;
            w_valid_nxt = 1'b1;
            w_pc_nxt    = w_pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_fetch;
            r_pc    <= RESET_PC;
            r_instr <= NOP_INSTR;
            r_pc4   <= 32'd0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_pc4   <= w_pc4_nxt;
            r_valid <= w_valid_nxt;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else if (branch_taken) begin
            r_flush_cnt <= r_flush_cnt + 32'd1;
        end else if (hdu_out) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign perf_stall_cycles = r_stall_cnt;
    assign perf_flush_count  = r_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module   : tb_if_stage
// Brief    : Self-checking bench for if_stage with an IF/ID scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_stage;

    localparam logic [31:0] c_nop = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        hdu_out;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pipe_ifid_instr;
    logic [31:0] pipe_ifid_pc4;
    logic        pipe_ifid_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flush_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] sb_q[$];
    logic [31:0] exp_pc;
    logic        r_hold_seen = 1'b0;

    if_stage #(.RESET_PC(32'h0), .NOP_INSTR(c_nop)) dut (
        .clk(clk), .reset(reset), .hdu_out(hdu_out),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .pipe_ifid_instr(pipe_ifid_instr), .pipe_ifid_pc4(pipe_ifid_pc4),
        .pipe_ifid_valid(pipe_ifid_valid)
`ifdef IF_PERF_CNT_EN
        , .perf_stall_cycles(perf_stall_cycles),
        .perf_flush_count(perf_flush_count)
`endif
    );

    always #5 clk = ~clk;

    // A stall cycle keeps the previous IF/ID entry, so it must not be popped twice.
    always @(posedge clk) r_hold_seen <= hdu_out && !branch_taken && !reset;

    always @(negedge clk) begin
        if (pipe_ifid_valid === 1'b1 && !r_hold_seen) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: instr=%h pc4=%h but no entry expected",
                         pipe_ifid_instr, pipe_ifid_pc4);
            end else begin
                logic [63:0] e;
                e = sb_q.pop_front();
                if ({pipe_ifid_instr, pipe_ifid_pc4} !== e) begin
                    n_fail++;
                    $display("FAIL sb_ifid: got instr=%h pc4=%h, want instr=%h pc4=%h",
                             pipe_ifid_instr, pipe_ifid_pc4, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic step(input logic rst, input logic br, input logic [31:0] tgt,
                        input logic hdu, input logic rdy, input logic [31:0] rd);
        reset = rst; branch_taken = br; branch_target = tgt;
        hdu_out = hdu; imem_ready = rdy; imem_rdata = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_one();
        sb_q.push_back({exp_pc ^ 32'hA5A5_0000, exp_pc + 32'd4});
        step(0, 0, 0, 0, 1, exp_pc ^ 32'hA5A5_0000);
        exp_pc = exp_pc + 32'd4;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 1, 32'h0);
        step(1, 0, 0, 0, 1, 32'h0);
        n_checks++;
        if ({imem_req, imem_addr, pipe_ifid_valid, pipe_ifid_instr, pipe_ifid_pc4}
            !== {1'b0, 32'h0, 1'b0, c_nop, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_state: req=%b addr=%h v=%b instr=%h pc4=%h, want 0/0/0/nop/0",
                     imem_req, imem_addr, pipe_ifid_valid, pipe_ifid_instr, pipe_ifid_pc4);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL req_after_reset: got %b want 1", imem_req);
        end
        exp_pc = 32'h0;
    endtask

    task automatic test_seq_fetch();
        for (int i = 0; i < 3; i++) begin
            fetch_one();
            n_checks++;
            if (imem_addr !== exp_pc) begin
                n_fail++;
                $display("FAIL seq_addr%0d: got %h want %h", i, imem_addr, exp_pc);
            end
        end
        step(0, 0, 0, 0, 0, 32'hFFFF_FFFF);
        n_checks++;
        if ({pipe_ifid_valid, pipe_ifid_instr, imem_addr} !== {1'b0, c_nop, exp_pc}) begin
            n_fail++;
            $display("FAIL not_ready_bubble: v=%b instr=%h addr=%h want 0/nop/%h",
                     pipe_ifid_valid, pipe_ifid_instr, imem_addr, exp_pc);
        end
    endtask

    task automatic test_stall();
        fetch_one();
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 1, 1, 32'hBAD0_0000);
            n_checks++;
            if ({imem_addr, pipe_ifid_valid, pipe_ifid_instr, pipe_ifid_pc4}
                !== {32'h10, 1'b1, 32'hA5A5_000C, 32'h10}) begin
                n_fail++;
                $display("FAIL stall_hold%0d: addr=%h v=%b instr=%h pc4=%h want 10/1/a5a5000c/10",
                         i, imem_addr, pipe_ifid_valid, pipe_ifid_instr, pipe_ifid_pc4);
            end
        end
        fetch_one();
        n_checks++;
        if (imem_addr !== 32'h14) begin
            n_fail++;
            $display("FAIL stall_resume: addr=%h want 00000014", imem_addr);
        end
    endtask

    task automatic test_flush_over_stall();
        step(0, 1, 32'h400, 1, 1, 32'h1111_1111);
        n_checks++;
        if ({pipe_ifid_valid, pipe_ifid_instr, pipe_ifid_pc4, imem_addr}
            !== {1'b0, c_nop, 32'h0, 32'h400}) begin
            n_fail++;
            $display("FAIL flush_stall: v=%b instr=%h pc4=%h addr=%h want 0/nop/0/400",
                     pipe_ifid_valid, pipe_ifid_instr, pipe_ifid_pc4, imem_addr);
        end
        exp_pc = 32'h400;
    endtask

    task automatic test_wait_flush();
        step(0, 1, 32'h83, 0, 0, 32'h0);
        n_checks++;
        if ({pipe_ifid_valid, imem_addr} !== {1'b0, 32'h80}) begin
            n_fail++;
            $display("FAIL wf_redirect: v=%b addr=%h want 0/80", pipe_ifid_valid, imem_addr);
        end
        step(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        n_checks++;
        if ({pipe_ifid_valid, pipe_ifid_instr, imem_addr} !== {1'b0, c_nop, 32'h80}) begin
            n_fail++;
            $display("FAIL wf_stale_drop: v=%b instr=%h addr=%h want 0/nop/80",
                     pipe_ifid_valid, pipe_ifid_instr, imem_addr);
        end
        sb_q.push_back({32'h1234_5678, 32'h84});
        step(0, 0, 0, 0, 1, 32'h1234_5678);
        n_checks++;
        if (imem_addr !== 32'h84) begin
            n_fail++;
            $display("FAIL wf_resume_addr: addr=%h want 84", imem_addr);
        end
    endtask

    task automatic test_wrap();
        step(0, 1, 32'hFFFF_FFFF, 0, 1, 32'h0);
        n_checks++;
        if (imem_addr !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_target: addr=%h want fffffffc", imem_addr);
        end
        sb_q.push_back({32'hCAFE_F00D, 32'h0});
        step(0, 0, 0, 0, 1, 32'hCAFE_F00D);
        n_checks++;
        if (imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_addr: addr=%h want 0", imem_addr);
        end
    endtask

    task automatic test_reset_mid_flush();
        step(0, 1, 32'h200, 0, 0, 32'h0);
        step(1, 0, 0, 0, 0, 32'h0);
        exp_pc = 32'h0;
        fetch_one();
        n_checks++;
        if (imem_addr !== 32'h4) begin
            n_fail++;
            $display("FAIL reset_mid_flush: addr=%h want 4", imem_addr);
        end
    endtask

`ifdef IF_PERF_CNT_EN
    task automatic test_perf();
        step(1, 0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 32'h0);
        step(0, 1, 32'h40, 1, 1, 32'h0);
        step(0, 1, 32'h40, 0, 1, 32'h0);
        n_checks++;
        if ({perf_stall_cycles, perf_flush_count} !== {32'd3, 32'd2}) begin
            n_fail++;
            $display("FAIL perf_counts: stall=%0d flush=%0d want 3/2",
                     perf_stall_cycles, perf_flush_count);
        end
        step(1, 0, 0, 0, 0, 32'h0);
        n_checks++;
        if ({perf_stall_cycles, perf_flush_count} !== 64'd0) begin
            n_fail++;
            $display("FAIL perf_reset: stall=%0d flush=%0d want 0/0",
                     perf_stall_cycles, perf_flush_count);
        end
    endtask
`endif

    initial begin
        reset = 1'b1; hdu_out = 1'b0; branch_taken = 1'b0;
        branch_target = 32'h0; imem_ready = 1'b0; imem_rdata = 32'h0;
        exp_pc = 32'h0;
        #1;
        test_reset();
        test_seq_fetch();
        test_stall();
        test_flush_over_stall();
        test_wait_flush();
        test_wrap();
        test_reset_mid_flush();
`ifdef IF_PERF_CNT_EN
        test_perf();
`endif
        step(0, 0, 0, 0, 0, 32'h0);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d entries left, want 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
